// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/mem_arb_lat_counter.sv
// Access latency counter: loads 1 on issue, counts while busy, flags done at
// MEM_LATENCY and then clears itself so it reads zero while idle.
module mem_arb_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic done
);

  logic [LAT_CNT_W-1:0] cnt;

  assign done = (cnt == LAT_CNT_W'(MEM_LATENCY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LAT_CNT_W'(1);
    end else if (done) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + LAT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and memory-stage accesses onto one fixed-latency memory.
// Define ARB_FAIRNESS_EN to force a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    InstrReq,
  input  logic [ADDR_WIDTH-1:0]   InstrAddr,
  output logic [DATA_WIDTH-1:0]   InstrRdata,
  output logic                    InstrValid,
  input  logic                    DataReq,
  input  logic                    DataWe,
  input  logic [ADDR_WIDTH-1:0]   DataAddr,
  input  logic [DATA_WIDTH-1:0]   DataWdata,
  input  logic [DATA_WIDTH/8-1:0] DataByteEn,
  output logic [DATA_WIDTH-1:0]   DataRdata,
  output logic                    DataValid,
  output logic                    StallF,
  output logic                    StallM,
  output logic                    MemReq,
  output logic                    MemWe,
  output logic [ADDR_WIDTH-1:0]   MemAddr,
  output logic [DATA_WIDTH-1:0]   MemWdata,
  output logic [DATA_WIDTH/8-1:0] MemByteEn,
  input  logic [DATA_WIDTH-1:0]   MemRdata
);

  arb_state_t            state, stateNext;
  owner_t                owner;
  logic                  isStore;
  logic [DATA_WIDTH-1:0] instrRdataQ, dataRdataQ;
  logic                  arbActive, grantD, grantI, issue, busy, latDone, fetchFirst;

  // Gating with rst_n keeps every output at zero while reset is held.
  assign arbActive = rst_n && (state == IDLE);
  assign grantD    = arbActive && DataReq && !fetchFirst;
  assign grantI    = arbActive && InstrReq && !grantD;
  assign issue     = grantD || grantI;
  assign busy      = (state != IDLE);

  mem_arb_lat_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) uLatCnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (issue),
    .inc  (busy),
    .done (latDone)
  );

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 2);
  logic [StarveW-1:0] starveCnt;

  assign fetchFirst = InstrReq && (starveCnt >= StarveW'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= '0;
    end else if (grantI) begin
      starveCnt <= '0;
    end else if (grantD && InstrReq) begin
      starveCnt <= starveCnt + StarveW'(1);
    end
  end
`else
  assign fetchFirst = 1'b0;
  if (STARVE_LIMIT > 0) begin : gStrictPriority
  end
`endif

  always_comb begin
    stateNext = state;
    MemReq    = 1'b0;
    MemWe     = 1'b0;
    MemAddr   = '0;
    MemWdata  = '0;
    MemByteEn = '0;
    unique case (state)
      IDLE:           if (grantD) stateNext = BUSY_D;
                      else if (grantI) stateNext = BUSY_I;
      BUSY_I, BUSY_D: if (latDone) stateNext = IDLE;
      default:        stateNext = IDLE;
    endcase
    if (grantD) begin
      MemReq    = 1'b1;
      MemWe     = DataWe;
      MemAddr   = DataAddr;
      MemWdata  = DataWdata;
      MemByteEn = DataByteEn;
    end else if (grantI) begin
      MemReq  = 1'b1;
      MemAddr = InstrAddr;
    end
  end

  // A requester that dropped Req (flush) gets no strobe and no data update.
  assign InstrValid = latDone && (owner == OWN_I) && InstrReq;
  assign DataValid  = latDone && (owner == OWN_D) && DataReq;

  // Registered copy holds the last result; the completing cycle forwards
  // MemRdata so data is visible in the same cycle as the strobe.
  assign InstrRdata = InstrValid ? MemRdata : instrRdataQ;
  assign DataRdata  = (DataValid && !isStore) ? MemRdata : dataRdataQ;

  assign StallF = rst_n && InstrReq && !InstrValid;
  assign StallM = rst_n && DataReq && !DataValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_I;
      isStore     <= 1'b0;
      instrRdataQ <= '0;
      dataRdataQ  <= '0;
    end else begin
      state <= stateNext;
      if (issue) begin
        owner   <= grantD ? OWN_D : OWN_I;
        isStore <= grantD && DataWe;
      end
      if (InstrValid) instrRdataQ <= MemRdata;
      if (DataValid && !isStore) dataRdataQ <= MemRdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model plus directed scenarios.
module tb_mem_port_arbiter;

  localparam int unsigned LAT   = 2;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InstrReq, DataReq, DataWe;
  logic [31:0] InstrAddr, DataAddr, DataWdata, MemRdata;
  logic [3:0]  DataByteEn;
  logic [31:0] InstrRdata, DataRdata, MemAddr, MemWdata;
  logic        InstrValid, DataValid, StallF, StallM, MemReq, MemWe;
  logic [3:0]  MemByteEn;

  mem_port_arbiter #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .MEM_LATENCY (LAT),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .InstrReq  (InstrReq),
    .InstrAddr (InstrAddr),
    .InstrRdata(InstrRdata),
    .InstrValid(InstrValid),
    .DataReq   (DataReq),
    .DataWe    (DataWe),
    .DataAddr  (DataAddr),
    .DataWdata (DataWdata),
    .DataByteEn(DataByteEn),
    .DataRdata (DataRdata),
    .DataValid (DataValid),
    .StallF    (StallF),
    .StallM    (StallM),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWdata  (MemWdata),
    .MemByteEn (MemByteEn),
    .MemRdata  (MemRdata)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;

  // Model: one outstanding transaction, completing LAT cycles after issue.
  logic        actValid = 1'b0;
  logic        actData, actStore;
  logic [31:0] actAddr;
  int          actDone;
  int          starve = 0;
  logic [31:0] expIRd = '0;
  logic [31:0] expDRd = '0;

  logic        smpMemReq, smpMemWe, smpIV, smpDV, smpSF, smpSM;
  logic [31:0] smpMemAddr, smpMemWdata, smpIRd, smpDRd;
  logic [3:0]  smpBe;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return (a * 32'h0001_0001) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Inputs for this cycle are already applied; drive memory, predict, compare.
  task automatic cycle();
    logic        eReq, eWe, eIV, eDV, doneNow, fetchWins;
    logic [31:0] eAddr, eWdata, resp;
    logic [3:0]  eBe;
    eReq = 1'b0; eWe = 1'b0; eIV = 1'b0; eDV = 1'b0;
    eAddr = '0; eWdata = '0; eBe = '0;
    cyc++;
    doneNow  = actValid && (cyc == actDone) && rst_n;
    resp     = doneNow ? memFn(actAddr) : (32'hA5A5_0000 | (cyc & 32'hFFFF));
    MemRdata = resp;
    if (!rst_n) begin
      actValid = 1'b0;
      starve   = 0;
      expIRd   = '0;
      expDRd   = '0;
    end else if (doneNow) begin
      if (!actData && InstrReq) begin
        eIV    = 1'b1;
        expIRd = resp;
      end
      if (actData && DataReq) begin
        eDV = 1'b1;
        if (!actStore) expDRd = resp;
      end
    end else if (!actValid) begin
`ifdef ARB_FAIRNESS_EN
      fetchWins = InstrReq && (!DataReq || starve >= int'(LIMIT));
`else
      fetchWins = InstrReq && !DataReq;
`endif
      if (DataReq && !fetchWins) begin
        eReq = 1'b1; eWe = DataWe; eAddr = DataAddr; eWdata = DataWdata; eBe = DataByteEn;
        actData = 1'b1; actStore = DataWe; actAddr = DataAddr;
        if (InstrReq) starve++;
      end else if (fetchWins) begin
        eReq = 1'b1; eAddr = InstrAddr;
        actData = 1'b0; actStore = 1'b0; actAddr = InstrAddr;
        starve = 0;
      end
      if (eReq) begin
        actValid = 1'b1;
        actDone  = cyc + int'(LAT);
      end
    end
    #4;
    smpMemReq = MemReq; smpMemWe = MemWe; smpMemAddr = MemAddr; smpMemWdata = MemWdata;
    smpBe = MemByteEn; smpIV = InstrValid; smpDV = DataValid; smpSF = StallF; smpSM = StallM;
    smpIRd = InstrRdata; smpDRd = DataRdata;
    chk1("MemReq", smpMemReq, eReq);
    chk1("MemWe", smpMemWe, eWe);
    chk32("MemAddr", smpMemAddr, eAddr);
    chk32("MemWdata", smpMemWdata, eWdata);
    chk32("MemByteEn", 32'(smpBe), 32'(eBe));
    chk1("InstrValid", smpIV, eIV);
    chk1("DataValid", smpDV, eDV);
    chk32("InstrRdata", smpIRd, expIRd);
    chk32("DataRdata", smpDRd, expDRd);
    chk1("StallF", smpSF, rst_n && InstrReq && !eIV);
    chk1("StallM", smpSM, rst_n && DataReq && !eDV);
    if (doneNow) actValid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [9:0] gotSeq, expSeq;
  int         nGrant;

  initial begin
    rst_n = 1'b0; InstrReq = 1'b0; DataReq = 1'b0; DataWe = 1'b0;
    InstrAddr = '0; DataAddr = '0; DataWdata = '0; DataByteEn = '0; MemRdata = '0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Single fetch
    cyc = 0;
    InstrReq = 1'b1; InstrAddr = 32'h0000_0010;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      if (i == 1) begin
        chk1("tp1_issue", smpMemReq, 1'b1);
        chk32("tp1_addr", smpMemAddr, 32'h0000_0010);
      end
      if (i <= 2) chk1("tp1_stallF", smpSF, 1'b1);
      if (i == 3) begin
        chk1("tp1_valid", smpIV, 1'b1);
        chk32("tp1_rdata", smpIRd, 32'h0050_0093);
      end
    end
    InstrReq = 1'b0;
    cycle();

    // Simultaneous requests: data first, fetch at T+LAT+1
    cyc = 0;
    InstrReq = 1'b1; InstrAddr = 32'h20;
    DataReq = 1'b1; DataWe = 1'b0; DataAddr = 32'h100; DataByteEn = 4'hF;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i == 1) chk32("tp2_data_first", smpMemAddr, 32'h100);
      if (i == 3) chk1("tp2_dvalid", smpDV, 1'b1);
      if (i == 4) begin
        chk1("tp2_fetch_issue", smpMemReq, 1'b1);
        chk32("tp2_fetch_addr", smpMemAddr, 32'h20);
      end
      if (i == 6) chk1("tp2_ivalid", smpIV, 1'b1);
      if (smpDV) DataReq = 1'b0;
      if (smpIV) InstrReq = 1'b0;
    end

    // Store
    cyc = 0;
    DataReq = 1'b1; DataWe = 1'b1; DataAddr = 32'h200; DataWdata = 32'hDEAD_BEEF; DataByteEn = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      if (i == 1) begin
        chk1("tp3_we", smpMemWe, 1'b1);
        chk32("tp3_wdata", smpMemWdata, 32'hDEAD_BEEF);
      end
      if (i == 3) begin
        chk1("tp3_dvalid", smpDV, 1'b1);
        chk32("tp3_rdata_held", smpDRd, memFn(32'h100));
      end
    end
    DataReq = 1'b0; DataWe = 1'b0; DataWdata = '0;

    // Flush: fetch dropped after issue, then a load issued at issue+3
    cyc = 0;
    InstrReq = 1'b1; InstrAddr = 32'h30;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i == 2 || i == 3) begin
        chk1("tp4_no_ivalid", smpIV, 1'b0);
        chk32("tp4_irdata_held", smpIRd, memFn(32'h20));
      end
      if (i == 3) chk1("tp4_busy_no_issue", smpMemReq, 1'b0);
      if (i == 4) chk32("tp4_idle_issue", smpMemAddr, 32'h44);
      if (i == 6) chk1("tp4_dvalid", smpDV, 1'b1);
      if (i == 1) InstrReq = 1'b0;
      if (i == 2) begin
        DataReq = 1'b1; DataAddr = 32'h44;
      end
      if (smpDV) DataReq = 1'b0;
    end

    // Reset while BUSY_D
    cyc = 0;
    DataReq = 1'b1; DataAddr = 32'h40;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (i == 2) begin
        chk1("tp5_rst_memreq", smpMemReq, 1'b0);
        chk1("tp5_rst_stallM", smpSM, 1'b0);
        chk32("tp5_rst_drdata", smpDRd, 32'h0);
      end
      if (i == 3) begin
        chk1("tp5_reissue", smpMemReq, 1'b1);
        chk1("tp5_no_stale_valid", smpDV, 1'b0);
      end
      if (i == 5) chk32("tp5_rdata", smpDRd, memFn(32'h40));
      if (i == 1) rst_n = 1'b0;
      if (i == 2) rst_n = 1'b1;
      if (smpDV) DataReq = 1'b0;
    end

    // Both requests held: grant pattern
    DataReq = 1'b1; DataAddr = 32'h500; InstrReq = 1'b1; InstrAddr = 32'h600;
    gotSeq = '0;
    nGrant = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (smpMemReq && nGrant < 10) begin
        gotSeq[nGrant] = (smpMemAddr == 32'h500);
        nGrant++;
      end
    end
`ifdef ARB_FAIRNESS_EN
    expSeq = 10'b01111_01111;
`else
    expSeq = 10'b11111_11111;
`endif
    chk32("tp6_grant_count", 32'(nGrant), 32'd10);
    chk32("tp6_grant_seq", 32'(gotSeq), 32'(expSeq));
    DataReq = 1'b0; InstrReq = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one fixed-latency, single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. It grants one requester per transaction and sequences the memory access with a small state machine. It returns read data with a valid strobe and produces per-stage stall signals so the pipeline holds while an access is outstanding. It sits between fetch_top/memwrite_top and the shared memory macro.

## Interface
- DATA_WIDTH, 32, data and instruction word width
- ADDR_WIDTH, 32, byte address width
- MEM_LATENCY, 2, cycles from issue (MemReq high) to MemRdata valid; legal range 1..7
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (used only with fairness enabled)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- InstrReq  in  1  fetch requests a read; held until InstrValid
- InstrAddr  in  ADDR_WIDTH  fetch address
- InstrRdata  out  DATA_WIDTH  instruction returned
- InstrValid  out  1  one-cycle strobe: InstrRdata valid
- DataReq  in  1  memory stage requests access; held until DataValid
- DataWe  in  1  1 = store, 0 = load
- DataAddr  in  ADDR_WIDTH  data address
- DataWdata  in  DATA_WIDTH  store data
- DataByteEn  in  DATA_WIDTH/8  store byte enables
- DataRdata  out  DATA_WIDTH  load data returned
- DataValid  out  1  one-cycle strobe: load data valid / store complete
- StallF  out  1  InstrReq & ~InstrValid
- StallM  out  1  DataReq & ~DataValid
- MemReq  out  1  one-cycle issue strobe to memory
- MemWe  out  1  write enable for issued access
- MemAddr  out  ADDR_WIDTH  issued address
- MemWdata  out  DATA_WIDTH  issued write data
- MemByteEn  out  DATA_WIDTH/8  issued byte enables
- MemRdata  in  DATA_WIDTH  read data, valid exactly MEM_LATENCY cycles after issue

## Operation
- States: IDLE, BUSY_I, BUSY_D. Registers: state, latency counter (3 bits), owner, starvation counter.
- IDLE: if either request is present, arbitrate and drive MemReq=1. Drive Mem* combinationally from the winner's inputs. Load counter=1. Go to BUSY_I or BUSY_D. If there is no request, stay; MemReq=0.
- Priority: DataReq wins over InstrReq, because the memory stage holds the older instruction. The fairness exception is described under Configuration.
- BUSY_x: counter increments each cycle. When counter==MEM_LATENCY, assert the owner's Valid and capture MemRdata to the owner's Rdata output. Return to IDLE next cycle. No new issue happens in a BUSY state.
- Rdata outputs are registered. They hold their last value until the next completion for that requester. Reset value is 0.
- Stores: MemRdata is ignored. DataValid still pulses at completion, so writes use the same timing as loads.
- Requester drops Req mid-transaction (flush): the transaction completes on memory. The Valid strobe is suppressed and the Rdata register is not updated.
- Inactive Mem* outputs are driven to 0 when MemReq=0.
- Reset (any time, including mid-transaction): state=IDLE, counters=0, all outputs 0. A memory response arriving after reset is ignored.

## Timing
- Issue in cycle T. Valid/Rdata are visible in cycle T+MEM_LATENCY. The earliest next issue is T+MEM_LATENCY+1.
- Throughput is one access per MEM_LATENCY+1 cycles.
- Stall outputs are combinational from Req and Valid, with no added latency.
- Simultaneous InstrReq and DataReq in IDLE: data is issued first. Fetch is issued in the next IDLE cycle (T+MEM_LATENCY+1), unless another data request pre-empts it.

## Configuration
- ARB_FAIRNESS_EN defined:
  - The starvation counter increments on each data grant made while InstrReq is pending.
  - It clears on every instruction grant.
  - When it reaches STARVE_LIMIT, the next IDLE arbitration grants fetch even if DataReq is high.
- ARB_FAIRNESS_EN undefined: strict data priority. The starvation counter is not instantiated and STARVE_LIMIT is unused.

## Structure
- Shared package mem_arb_pkg:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D}
  - owner_t enum {OWN_I, OWN_D}
  - constant LAT_CNT_W = 3
- One sub-module: mem_arb_lat_counter. It holds the load/increment counter and emits done when it reaches MEM_LATENCY.

## Test plan
- Single fetch, MEM_LATENCY=2: InstrReq at cycle 1, addr 0x0000_0010, memory returns 0x0050_0093 at cycle 3. Required: MemReq at cycle 1, InstrValid and InstrRdata=0x0050_0093 at cycle 3, StallF high in cycles 1–2.
- Simultaneous requests: both Req high at cycle 1, DataAddr 0x100. Required: MemAddr=0x100 at cycle 1, DataValid at cycle 3, fetch issued at cycle 4, InstrValid at cycle 6.
- Store: DataWe=1, DataWdata=0xDEAD_BEEF, DataByteEn=0xF. Required: MemWe=1, MemWdata=0xDEAD_BEEF on the issue cycle, DataValid 2 cycles later, DataRdata unchanged.
- Flush: InstrReq dropped one cycle after issue. Required: no InstrValid, InstrRdata holds its previous value, arbiter back in IDLE at issue+3.
- Reset mid-transaction: rst_n low for 1 cycle while in BUSY_D. Required: all outputs 0 immediately, no DataValid, next request issued normally.
- Starvation (ARB_FAIRNESS_EN, STARVE_LIMIT=4): DataReq and InstrReq held high continuously. Required: four data grants, then one fetch grant, repeating. Without the macro, fetch is never granted while DataReq stays high.
